// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared address-field and FSM state types for the instruction cache
package cpu_types_pkg;
  localparam int ICACHE_IDX_W = 4;
  typedef struct packed {
    logic [29-ICACHE_IDX_W:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0] bytoff;
  } icachef_t;
  typedef enum logic {IDLE, FETCH} icache_state_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: datapath fetch port and memory-controller read port of the instruction cache
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  modport slave (input imemREN, imemaddr, iload, iwait, output ihit, imemload, iREN, iaddr);
  modport master (output imemREN, imemaddr, iload, iwait, input ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_frame_array.sv
// icache_frame_array: direct-mapped valid/tag/data frames, one write port, combinational read
module icache_frame_array #(
  parameter int SETS = 16,
  parameter int IW = $clog2(SETS),
  parameter int TW = 30 - IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [TW-1:0] wtag,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] ridx,
  output logic          rvalid,
  output logic [TW-1:0] rtag,
  output logic [31:0]   rdata
);
  logic [SETS-1:0] valid_q, valid_d;
  logic [TW-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS];
  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];
  // a fill marks its frame valid
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[widx] = 1'b1;
  end
  // valid bits reset; tag and data storage is written only by fills
  always_ff @(posedge clk) begin
    valid_q <= rst ? '0 : valid_d;
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-frame instruction cache; ICACHE_STATS_EN adds hit/miss counters
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  icache_if.slave     bus
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  icache_state_t state_q, state_d;
  icachef_t      miss_q, miss_d;
  logic [31:0]   maddr, rdata;
  logic [TW-1:0] rtag;
  logic          rvalid, hit, miss, fill;
  assign maddr         = miss_q;
  assign bus.ihit      = hit;
  assign bus.imemload  = hit ? rdata : 32'h0;
  assign bus.iREN      = state_q == FETCH;
  assign bus.iaddr     = state_q == FETCH ? maddr : 32'h0;
  icache_frame_array #(.SETS(SETS), .IW(IW), .TW(TW)) u_frames (
    .clk(CLK), .rst(RST), .we(fill && !RST),
    .widx(maddr[IW+1:2]), .wtag(maddr[31:IW+2]), .wdata(bus.iload),
    .ridx(bus.imemaddr[IW+1:2]), .rvalid(rvalid), .rtag(rtag), .rdata(rdata)
  );
  // hit/miss decode and next state; a redirect during FETCH still completes the latched fill
  always_comb begin
    hit     = state_q == IDLE && bus.imemREN && rvalid && rtag == bus.imemaddr[31:IW+2];
    miss    = state_q == IDLE && bus.imemREN && !hit;
    fill    = state_q == FETCH && !bus.iwait;
    state_d = miss ? FETCH : fill ? IDLE : state_q;
    miss_d  = miss ? icachef_t'(bus.imemaddr & ~32'h3) : miss_q;
  end
  // state and miss-address registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  // saturating event counters
  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, hit && hit_count_q != '1};
    miss_count_d = miss_count_q + {31'd0, miss && miss_count_q != '1};
  end
  // counter registers
  always_ff @(posedge CLK) begin
    hit_count_q  <= RST ? '0 : hit_count_d;
    miss_count_q <= RST ? '0 : miss_count_d;
  end
`endif
endmodule
